// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit MIPS-subset executor and its fetch/decode stage:
// opcode and func constants, instruction-format codes, fetch FSM states.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SLT    = 6'h2A;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DECODE = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

    // Format class of an in-range instruction, from its opcode alone.
    function automatic fmt_e fmt_of(input logic [5:0] opcode);
        if (opcode == OP_RTYPE) begin
            return FMT_R;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            return FMT_J;
        end else begin
            return FMT_I;
        end
    endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// PC request / decoded-field response bundle between the executor (master)
// and the fetch/decode stage (slave).
interface instr_fetch_decode_if #(
    parameter int PC_W = 8
);
    logic               req_valid;
    logic [PC_W-1:0]    req_pc;
    logic               req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    cpu_pkg::fmt_e      out_fmt;
    logic [5:0]         out_opcode;
    logic [4:0]         out_rs;
    logic [4:0]         out_rt;
    logic [4:0]         out_rd;
    logic [4:0]         out_shamt;
    logic [5:0]         out_func;
    logic [15:0]        out_imm;
    logic [25:0]        out_target;
    logic [PC_W-1:0]    out_pc;
    logic               out_oor;

    modport master (
        output req_valid, req_pc, out_ready,
        input  req_ready, out_valid, out_instr, out_fmt, out_opcode, out_rs, out_rt,
               out_rd, out_shamt, out_func, out_imm, out_target, out_pc, out_oor
    );

    modport slave (
        input  req_valid, req_pc, out_ready,
        output req_ready, out_valid, out_instr, out_fmt, out_opcode, out_rs, out_rt,
               out_rd, out_shamt, out_func, out_imm, out_target, out_pc, out_oor
    );
endinterface

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port, one synchronous read-first
// read port. Contents are not reset so a loaded program survives rst_n.
module imem_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [31:0]    wdata,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [31:0]    rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Write and read in one block so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: accepts a PC, reads the instruction memory, and presents
// the split instruction fields until the executor consumes them.
module instr_fetch_decode #(
    parameter int IMEM_DEPTH = 16,
    parameter int PC_W       = 8,
    parameter int AW         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [31:0]      ld_data,
    instr_fetch_decode_if.slave bus
);
    import cpu_pkg::*;

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);

    state_e            state_q,     state_d;
    logic [PC_W-1:0]   pc_q,        pc_d;
    logic              req_ready_q, req_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q,     instr_d;
    fmt_e              fmt_q,       fmt_d;
    logic              oor_q,       oor_d;
    logic [PC_W-1:0]   out_pc_q,    out_pc_d;

    logic [31:0]       rdata;
    logic              pc_oor;

    // A load strobe coinciding with reset is discarded.
    imem_ram #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
        .clk   (clk),
        .we    (ld_en & rst_n),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (state_q == ST_READ),
        .raddr (pc_q[AW-1:0]),
        .rdata (rdata)
    );

    // Full-width compare so PCs beyond the memory never alias onto low words.
    assign pc_oor = (pc_q >= DEPTH_PC);

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_ready_d = req_ready_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        fmt_d       = fmt_q;
        oor_d       = oor_q;
        out_pc_d    = out_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    pc_d        = bus.req_pc;
                    req_ready_d = 1'b0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                oor_d       = pc_oor;
                instr_d     = pc_oor ? 32'h0 : rdata;
                fmt_d       = pc_oor ? FMT_BAD : fmt_of(rdata[31:26]);
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, PC latch and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            fmt_q       <= FMT_R;
            oor_q       <= 1'b0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            fmt_q       <= fmt_d;
            oor_q       <= oor_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_instr  = instr_q;
    assign bus.out_fmt    = fmt_q;
    assign bus.out_opcode = instr_q[31:26];
    assign bus.out_rs     = instr_q[25:21];
    assign bus.out_rt     = instr_q[20:16];
    assign bus.out_rd     = instr_q[15:11];
    assign bus.out_shamt  = instr_q[10:6];
    assign bus.out_func   = instr_q[5:0];
    assign bus.out_imm    = instr_q[15:0];
    assign bus.out_target = instr_q[25:0];
    assign bus.out_pc     = out_pc_q;
    assign bus.out_oor    = oor_q;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed scenarios plus a randomized run
// against a word-array model of the instruction memory.
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [16];

    typedef struct {
        logic        timeout;
        logic        rr_acc;
        logic        v1;
        logic        v2;
        logic [31:0] instr;
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] target;
        logic [7:0]  pc;
        logic        oor;
        logic        stable;
        logic        v_end;
        logic        rr_end;
    } obs_t;

    instr_fetch_decode_if #(.PC_W(8)) bus ();

    instr_fetch_decode #(.IMEM_DEPTH(16), .PC_W(8), .AW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference: word at pc, or zero when pc lies beyond the 16-word memory.
    function automatic logic [31:0] exp_instr(input logic [7:0] pc);
        return (pc >= 8'd16) ? 32'h0 : model[pc[3:0]];
    endfunction

    function automatic logic [1:0] exp_fmt(input logic [7:0] pc);
        logic [5:0] op;
        if (pc >= 8'd16) return 2'd3;
        op = model[pc[3:0]][31:26];
        if (op == 6'd0) return 2'd0;
        if (op == 6'd2 || op == 6'd3) return 2'd2;
        return 2'd1;
    endfunction

    task automatic ld_word(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); @(negedge clk);
        ld_en = 1'b0;
        model[a] = d;
    endtask

    // Issue one fetch; optionally write imem during the READ cycle; hold
    // out_ready low for 'hold' cycles (with a stray req_valid) before consuming.
    task automatic fetch(input logic [7:0] pc, input int hold, input bit ld_rd,
                         input logic [3:0] la, input logic [31:0] lw, output obs_t o);
        int n;
        o = '{default: '0};
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        o.timeout = (n >= 20);
        bus.req_valid = 1'b1; bus.req_pc = pc; bus.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        o.rr_acc = bus.req_ready;
        bus.req_valid = 1'b0;
        if (ld_rd) begin
            ld_en = 1'b1; ld_addr = la; ld_data = lw;
        end
        @(posedge clk); @(negedge clk);
        o.v1 = bus.out_valid;
        ld_en = 1'b0;
        @(posedge clk); @(negedge clk);
        o.v2 = bus.out_valid;
        o.instr = bus.out_instr; o.fmt = bus.out_fmt; o.opcode = bus.out_opcode;
        o.rs = bus.out_rs; o.rt = bus.out_rt; o.rd = bus.out_rd; o.shamt = bus.out_shamt;
        o.func = bus.out_func; o.imm = bus.out_imm; o.target = bus.out_target;
        o.pc = bus.out_pc; o.oor = bus.out_oor;
        o.stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1; bus.req_pc = pc ^ 8'h05;
            @(posedge clk); @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.out_instr !== o.instr ||
                bus.out_fmt !== o.fmt || bus.out_pc !== o.pc || bus.out_oor !== o.oor)
                o.stable = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        o.v_end = bus.out_valid; o.rr_end = bus.req_ready;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
        checks++; if (bus.out_fmt !== 2'd0 || bus.out_pc !== 8'd0 || bus.out_oor !== 1'b0)
            begin errors++; $display("FAIL reset_fields fmt=%0d pc=%0d oor=%b exp all 0", bus.out_fmt, bus.out_pc, bus.out_oor); end
    endtask

    task automatic test_rtype();
        obs_t o;
        ld_word(4'd2, 32'h0061202A);
        fetch(8'd2, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL rtype_idle_wait got=timeout exp=ready"); end
        checks++; if (o.rr_acc !== 1'b0) begin errors++; $display("FAIL rtype_req_ready_busy got=%b exp=0", o.rr_acc); end
        checks++; if (o.v1 !== 1'b0 || o.v2 !== 1'b1) begin errors++; $display("FAIL rtype_latency got v1=%b v2=%b exp v1=0 v2=1", o.v1, o.v2); end
        checks++; if (o.fmt !== 2'd0) begin errors++; $display("FAIL rtype_fmt got=%0d exp=0", o.fmt); end
        checks++; if (o.rs !== 5'd3 || o.rt !== 5'd1 || o.rd !== 5'd4)
            begin errors++; $display("FAIL rtype_regs got rs=%0d rt=%0d rd=%0d exp 3 1 4", o.rs, o.rt, o.rd); end
        checks++; if (o.func !== 6'h2A) begin errors++; $display("FAIL rtype_func got=%h exp=2a", o.func); end
        checks++; if (o.pc !== 8'd2 || o.instr !== 32'h0061202A)
            begin errors++; $display("FAIL rtype_pc_instr got pc=%0d instr=%h exp 2 0061202a", o.pc, o.instr); end
        checks++; if (o.v_end !== 1'b0 || o.rr_end !== 1'b1)
            begin errors++; $display("FAIL rtype_consume got valid=%b ready=%b exp 0 1", o.v_end, o.rr_end); end
    endtask

    task automatic test_itype();
        obs_t o;
        ld_word(4'd4, 32'h2405000A);
        ld_word(4'd10, 32'h1404FFFB);
        fetch(8'd4, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.fmt !== 2'd1 || o.rs !== 5'd0 || o.rt !== 5'd5 || o.imm !== 16'h000A)
            begin errors++; $display("FAIL itype_w4 got fmt=%0d rs=%0d rt=%0d imm=%h exp 1 0 5 000a", o.fmt, o.rs, o.rt, o.imm); end
        fetch(8'd10, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.fmt !== 2'd1 || o.opcode !== 6'd5 || o.rt !== 5'd4 || o.imm !== 16'hFFFB)
            begin errors++; $display("FAIL itype_w10 got fmt=%0d op=%0d rt=%0d imm=%h exp 1 5 4 fffb", o.fmt, o.opcode, o.rt, o.imm); end
    endtask

    task automatic test_jtype_hold();
        obs_t o;
        ld_word(4'd13, 32'h0C000000);
        fetch(8'd13, 5, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.fmt !== 2'd2 || o.opcode !== 6'd3 || o.target !== 26'd0)
            begin errors++; $display("FAIL jtype_fields got fmt=%0d op=%0d tgt=%h exp 2 3 0", o.fmt, o.opcode, o.target); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL jtype_hold_stable got=%b exp=1", o.stable); end
        checks++; if (o.rr_end !== 1'b1) begin errors++; $display("FAIL jtype_release got ready=%b exp=1", o.rr_end); end
    endtask

    task automatic test_oor();
        obs_t o;
        ld_word(4'd0, 32'hDEADBEEF);
        ld_word(4'd14, 32'h24A5FFFF);
        ld_word(4'd15, 32'h08000003);
        fetch(8'd14, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.oor !== 1'b0 || o.fmt !== 2'd1 || o.instr !== 32'h24A5FFFF)
            begin errors++; $display("FAIL oor_pc14 got oor=%b fmt=%0d instr=%h exp 0 1 24a5ffff", o.oor, o.fmt, o.instr); end
        fetch(8'd15, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.oor !== 1'b0 || o.fmt !== 2'd2 || o.instr !== 32'h08000003)
            begin errors++; $display("FAIL oor_pc15 got oor=%b fmt=%0d instr=%h exp 0 2 08000003", o.oor, o.fmt, o.instr); end
        fetch(8'd16, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.oor !== 1'b1 || o.fmt !== 2'd3 || o.instr !== 32'h0 || o.v2 !== 1'b1)
            begin errors++; $display("FAIL oor_pc16 got oor=%b fmt=%0d instr=%h valid=%b exp 1 3 0 1", o.oor, o.fmt, o.instr, o.v2); end
        checks++; if (o.rs !== 5'd0 || o.imm !== 16'd0 || o.target !== 26'd0 || o.pc !== 8'd16)
            begin errors++; $display("FAIL oor_pc16_fields got rs=%0d imm=%h tgt=%h pc=%0d exp 0 0 0 16", o.rs, o.imm, o.target, o.pc); end
        fetch(8'd255, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.oor !== 1'b1 || o.fmt !== 2'd3 || o.instr !== 32'h0)
            begin errors++; $display("FAIL oor_pc255 got oor=%b fmt=%0d instr=%h exp 1 3 0", o.oor, o.fmt, o.instr); end
    endtask

    task automatic test_read_first();
        obs_t o;
        logic [31:0] old_w;
        old_w = model[2];
        fetch(8'd2, 0, 1'b1, 4'd2, 32'h00A52021, o);
        model[2] = 32'h00A52021;
        checks++; if (o.instr !== old_w) begin errors++; $display("FAIL readfirst_old got=%h exp=%h", o.instr, old_w); end
        fetch(8'd2, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.instr !== 32'h00A52021 || o.func !== 6'h21)
            begin errors++; $display("FAIL readfirst_new got=%h exp=00a52021", o.instr); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        ld_word(4'd7, 32'h8C430004);
        // abort in DECODE, with a load that must be dropped
        bus.req_valid = 1'b1; bus.req_pc = 8'd7;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin errors++; $display("FAIL rstmid_decode got valid=%b ready=%b exp 0 1", bus.out_valid, bus.req_ready); end
        ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'hFFFFFFFF;
        @(posedge clk); @(negedge clk);
        ld_en = 1'b0;
        rst_n = 1'b1;
        // abort in OUT while fields are valid
        bus.req_valid = 1'b1; bus.req_pc = 8'd7;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got valid=%b exp=1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.out_instr !== 32'h0)
            begin errors++; $display("FAIL rstmid_out got valid=%b ready=%b instr=%h exp 0 1 0", bus.out_valid, bus.req_ready, bus.out_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(8'd7, 0, 1'b0, 4'd0, 32'h0, o);
        checks++; if (o.instr !== 32'h8C430004 || o.fmt !== 2'd1)
            begin errors++; $display("FAIL rstmid_refetch got instr=%h fmt=%0d exp 8c430004 1", o.instr, o.fmt); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [5:0]  ops [8];
        logic [31:0] w, ei;
        logic [7:0]  pc;
        logic [3:0]  a;
        ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h03; ops[3] = 6'h04;
        ops[4] = 6'h05; ops[5] = 6'h09; ops[6] = 6'h23; ops[7] = 6'h3F;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom;
                w[31:26] = ops[$urandom_range(0, 7)];
                a = 4'($urandom_range(0, 15));
                ld_word(a, w);
            end
            pc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 17));
            ei = exp_instr(pc);
            fetch(pc, $urandom_range(0, 2), 1'b0, 4'd0, 32'h0, o);
            checks++; if (o.instr !== ei || o.fmt !== exp_fmt(pc) || o.oor !== (pc >= 8'd16) || o.pc !== pc)
                begin errors++; $display("FAIL rand_fetch pc=%0d got instr=%h fmt=%0d oor=%b exp instr=%h fmt=%0d", pc, o.instr, o.fmt, o.oor, ei, exp_fmt(pc)); end
            checks++; if ({o.opcode, o.rs, o.rt, o.rd, o.shamt, o.func} !== ei || o.imm !== ei[15:0] || o.target !== ei[25:0])
                begin errors++; $display("FAIL rand_fields pc=%0d got op=%h rs=%0d rt=%0d imm=%h exp instr=%h", pc, o.opcode, o.rs, o.rt, o.imm, ei); end
            checks++; if (o.v1 !== 1'b0 || o.v2 !== 1'b1 || o.stable !== 1'b1 || o.rr_end !== 1'b1 || o.timeout !== 1'b0)
                begin errors++; $display("FAIL rand_handshake pc=%0d got v1=%b v2=%b stable=%b ready=%b", pc, o.v1, o.v2, o.stable, o.rr_end); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        // clear memory through the load port so the model starts known
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) ld_word(4'(i), 32'h0);
        test_rtype();
        test_itype();
        test_jtype_hold();
        test_oor();
        test_read_first();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "timeout");
    end

endmodule
